// File: rtl/data_mem_ctrl_if.sv
// Core-side and memory-side bus bundle for data_mem_ctrl.
// Byte lanes are packed [0:3][7:0]: lane i = byte i, lane i pairs with mem_be[i].
// Modports:
//   slave  - controller view (core request/memory response in, load data/stall/memory request out)
//   master - environment view (core pipeline plus backing memory)
// Signals:
//   core_addr, core_wdata, core_rd, core_wr, core_is_word   core request
//   core_rdata, core_stall, core_err                        core response
//   mem_req, mem_we, mem_addr, mem_be, mem_wdata            memory request
//   mem_rdata, mem_ack                                      memory response
interface data_mem_ctrl_if;
   logic [31:0]      core_addr;
   logic [0:3][7:0]  core_wdata;
   logic             core_rd;
   logic             core_wr;
   logic             core_is_word;
   logic [0:3][7:0]  core_rdata;
   logic             core_stall;
   logic             core_err;
   logic             mem_req;
   logic             mem_we;
   logic [31:0]      mem_addr;
   logic [3:0]       mem_be;
   logic [0:3][7:0]  mem_wdata;
   logic [0:3][7:0]  mem_rdata;
   logic             mem_ack;

   modport slave (
      input  core_addr, core_wdata, core_rd, core_wr, core_is_word,
      input  mem_rdata, mem_ack,
      output core_rdata, core_stall, core_err,
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );

   modport master (
      output core_addr, core_wdata, core_rd, core_wr, core_is_word,
      output mem_rdata, mem_ack,
      input  core_rdata, core_stall, core_err,
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data memory controller between the core MEM stage and a handshaked backing memory.
// Each load/store becomes one mem_req..mem_ack transaction; the core is frozen via
// core_stall (combinational) until the transaction completes or times out.
// Ports:
//   clk    - rising-edge clock
//   rst_b  - asynchronous, active-high reset
//   bus    - data_mem_ctrl_if.slave (core request/response, memory request/response)
// Parameter:
//   ACK_TIMEOUT - WAIT_ACK cycles allowed before the transaction is aborted (>= 1)
// Optional feature:
//   DATA_MEM_WRITE_BUFFER_EN - one-entry posted write buffer; stores are accepted
//   without stalling and drained in the background.
module data_mem_ctrl #(
   parameter int unsigned ACK_TIMEOUT = 255
) (
   input  logic           clk,
   input  logic           rst_b,
   data_mem_ctrl_if.slave bus
);

   localparam int unsigned CNT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REQ      = 2'd1;
   localparam logic [1:0] WAIT_ACK = 2'd2;
   localparam logic [1:0] DONE     = 2'd3;

   logic [1:0]       state, state_nxt;
   logic             mem_req_q, mem_req_nxt;
   logic             mem_we_q, mem_we_nxt;
   logic [31:0]      mem_addr_q, mem_addr_nxt;
   logic [3:0]       mem_be_q, mem_be_nxt;
   logic [0:3][7:0]  mem_wdata_q, mem_wdata_nxt;
   logic [0:3][7:0]  rdata_q, rdata_nxt;
   logic             err_q, err_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             stall;

   logic             req_any;
   logic [3:0]       be_new;
   logic [0:3][7:0]  wdata_new;

`ifdef DATA_MEM_WRITE_BUFFER_EN
   logic             posted_q, posted_nxt;
`endif

   // Request decode: byte accesses enable one lane and replicate byte 0 across all lanes
   always_comb begin
      req_any = bus.core_rd | bus.core_wr;
      be_new  = bus.core_is_word ? 4'b1111 : (4'b0001 << bus.core_addr[1:0]);
      for (int i = 0; i < 4; i++) begin
         wdata_new[i] = bus.core_is_word ? bus.core_wdata[i] : bus.core_wdata[0];
      end
   end

   // Next-state and next-register values
   always_comb begin
      state_nxt     = state;
      mem_req_nxt   = mem_req_q;
      mem_we_nxt    = mem_we_q;
      mem_addr_nxt  = mem_addr_q;
      mem_be_nxt    = mem_be_q;
      mem_wdata_nxt = mem_wdata_q;
      rdata_nxt     = rdata_q;
      err_nxt       = err_q;
      cnt_nxt       = cnt_q;
      stall         = 1'b0;
`ifdef DATA_MEM_WRITE_BUFFER_EN
      posted_nxt    = posted_q;
`endif

      case (state)
         IDLE: begin
            if (req_any) begin
               // Simultaneous rd and wr is serviced as a write
               mem_we_nxt    = bus.core_wr;
               mem_addr_nxt  = {bus.core_addr[31:2], 2'b00};
               mem_be_nxt    = be_new;
               mem_wdata_nxt = wdata_new;
               mem_req_nxt   = 1'b1;
               cnt_nxt       = '0;
               state_nxt     = REQ;
               stall         = 1'b1;
`ifdef DATA_MEM_WRITE_BUFFER_EN
               // Store is posted: the core moves on while it drains
               if (bus.core_wr) begin
                  posted_nxt = 1'b1;
                  stall      = 1'b0;
               end
`endif
            end
         end

         REQ: begin
            state_nxt = WAIT_ACK;
            stall     = 1'b1;
`ifdef DATA_MEM_WRITE_BUFFER_EN
            if (posted_q) stall = req_any;
`endif
         end

         WAIT_ACK: begin
            stall = 1'b1;
`ifdef DATA_MEM_WRITE_BUFFER_EN
            if (posted_q) stall = req_any;
`endif
            if (bus.mem_ack) begin
               mem_req_nxt = 1'b0;
               if (!mem_we_q) rdata_nxt = bus.mem_rdata;
               state_nxt   = DONE;
            end else if (cnt_q == CNT_LAST) begin
               // Abort: sticky error, loads return zero
               mem_req_nxt = 1'b0;
               err_nxt     = 1'b1;
               if (!mem_we_q) rdata_nxt = '0;
               state_nxt   = DONE;
            end else begin
               cnt_nxt = cnt_q + CNT_W'(1);
            end
         end

         DONE: begin
            state_nxt = IDLE;
            stall     = 1'b0;
`ifdef DATA_MEM_WRITE_BUFFER_EN
            // A request that arrived during the drain is still waiting for IDLE
            if (posted_q) stall = req_any;
            posted_nxt = 1'b0;
`endif
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst_b) begin
      if (rst_b) begin
         state       <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
`ifdef DATA_MEM_WRITE_BUFFER_EN
         posted_q    <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         mem_req_q   <= mem_req_nxt;
         mem_we_q    <= mem_we_nxt;
         mem_addr_q  <= mem_addr_nxt;
         mem_be_q    <= mem_be_nxt;
         mem_wdata_q <= mem_wdata_nxt;
         rdata_q     <= rdata_nxt;
         err_q       <= err_nxt;
         cnt_q       <= cnt_nxt;
`ifdef DATA_MEM_WRITE_BUFFER_EN
         posted_q    <= posted_nxt;
`endif
      end
   end

   assign bus.mem_req    = mem_req_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_be     = mem_be_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.core_rdata = rdata_q;
   assign bus.core_err   = err_q;
   assign bus.core_stall = stall;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. The initial block plays the core; an
// always block plays the backing memory (acks a programmable number of cycles
// after mem_req rises and logs every issued transaction).
module tb_data_mem_ctrl;
   localparam int unsigned T = 8;

   logic clk = 1'b0;
   logic rst_b;
   always #5 clk = ~clk;

   data_mem_ctrl_if bus ();

   data_mem_ctrl #(.ACK_TIMEOUT(T)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   // Memory responder state
   int              ack_dly = 0;     // 0 = never ack
   logic [0:3][7:0] resp = '0;
   bit              force_ack = 1'b0;
   bit              req_seen = 1'b0;
   int              rcnt = 0;
   int              rises = 0;
   logic [31:0]     cap_addr[$];
   logic [3:0]      cap_be[$];
   logic [0:3][7:0] cap_wd[$];
   logic            cap_we[$];

   // Reference model state
   logic [0:3][7:0] exp_rdata = '0;
   bit              exp_err = 1'b0;

   always @(negedge clk) begin
      bus.mem_ack = 1'b0;
      if (bus.mem_req === 1'b1) begin
         if (!req_seen) begin
            req_seen = 1'b1;
            rcnt     = 0;
            rises++;
            cap_addr.push_back(bus.mem_addr);
            cap_be.push_back(bus.mem_be);
            cap_wd.push_back(bus.mem_wdata);
            cap_we.push_back(bus.mem_we);
         end else begin
            rcnt++;
         end
         if (ack_dly != 0 && rcnt == ack_dly) bus.mem_ack = 1'b1;
      end else begin
         req_seen = 1'b0;
      end
      if (force_ack) bus.mem_ack = 1'b1;
      bus.mem_rdata = bus.mem_ack ? resp : 32'($urandom);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      rises = 0;
      cap_addr.delete();
      cap_be.delete();
      cap_wd.delete();
      cap_we.delete();
   endtask

   // One core access; d = memory ack delay after mem_req rises (0 = never)
   task automatic run_op(input string tag, input bit rd, input bit wr, input bit word,
                         input logic [31:0] a, input logic [0:3][7:0] wd,
                         input int d, input logic [0:3][7:0] r);
      int stalls;
      int exp_stalls;
      int n;
      bit to;
      bit is_wr;
      logic [0:3][7:0] ew;
      logic [3:0] eb;

      ack_dly = d;
      resp    = r;
      clear_log();
      is_wr = wr;
      to    = (d == 0) || (d > int'(T));
      exp_stalls = to ? 2 + int'(T) : 2 + d;
`ifdef DATA_MEM_WRITE_BUFFER_EN
      if (is_wr) exp_stalls = 0;
`endif
      for (int i = 0; i < 4; i++) ew[i] = word ? wd[i] : wd[0];
      eb = word ? 4'hF : 4'(1 << a[1:0]);

      @(negedge clk);
      bus.core_rd      = rd;
      bus.core_wr      = wr;
      bus.core_is_word = word;
      bus.core_addr    = a;
      bus.core_wdata   = wd;
      #1;
      stalls = 0;
      while (bus.core_stall === 1'b1 && stalls < 60) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      check({tag, " stall_cycles"}, 64'(stalls), 64'(exp_stalls));
      if (exp_stalls != 0) check({tag, " mem_req_done"}, 64'(bus.mem_req), 64'(0));

      @(negedge clk);
      bus.core_rd = 1'b0;
      bus.core_wr = 1'b0;
      #1;
      n = 0;
      while ((bus.mem_req !== 1'b0 || rises == 0) && n < 60) begin
         n++;
         @(negedge clk);
         #1;
      end

      if (!is_wr) exp_rdata = to ? '0 : r;
      if (to) exp_err = 1'b1;

      check({tag, " txn_count"}, 64'(rises), 64'(1));
      if (cap_addr.size() > 0) begin
         check({tag, " mem_addr"},  64'(cap_addr[0]), 64'(a & 32'hFFFF_FFFC));
         check({tag, " mem_be"},    64'(cap_be[0]),   64'(eb));
         check({tag, " mem_wdata"}, 64'(cap_wd[0]),   64'(ew));
         check({tag, " mem_we"},    64'(cap_we[0]),   64'(is_wr));
      end
      check({tag, " core_rdata"}, 64'(bus.core_rdata), 64'(exp_rdata));
      check({tag, " core_err"},   64'(bus.core_err),   64'(exp_err));
   endtask

   initial begin
      logic [31:0]     ra;
      logic [0:3][7:0] rw;
      logic [0:3][7:0] rr;
      int              kind;
      int              stalls;

      rst_b            = 1'b1;
      bus.core_rd      = 1'b0;
      bus.core_wr      = 1'b0;
      bus.core_is_word = 1'b0;
      bus.core_addr    = '0;
      bus.core_wdata   = '0;

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst mem_req",    64'(bus.mem_req),    64'(0));
      check("rst mem_we",     64'(bus.mem_we),     64'(0));
      check("rst mem_be",     64'(bus.mem_be),     64'(0));
      check("rst mem_addr",   64'(bus.mem_addr),   64'(0));
      check("rst mem_wdata",  64'(bus.mem_wdata),  64'(0));
      check("rst core_rdata", 64'(bus.core_rdata), 64'(0));
      check("rst core_err",   64'(bus.core_err),   64'(0));
      check("rst core_stall", 64'(bus.core_stall), 64'(0));
      @(negedge clk);
      rst_b = 1'b0;
      repeat (2) @(negedge clk);

      // Directed: word load, byte store, rd+wr collision, unaligned word
      run_op("ld10", 1'b1, 1'b0, 1'b1, 32'h0000_0010, 32'h0, 2, {8'h11, 8'h22, 8'h33, 8'h44});
      run_op("stb103", 1'b0, 1'b1, 1'b0, 32'h0000_0103, {8'hAB, 8'h01, 8'h02, 8'h03}, 1, 32'h0);
      run_op("rdwr40", 1'b1, 1'b1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 3, 32'h1234_5678);
      run_op("ldw_unal", 1'b1, 1'b0, 1'b1, 32'h0000_1237, 32'h0, 1, 32'h8765_4321);

      // Randomized accesses
      for (int k = 0; k < 16; k++) begin
         kind = int'($urandom_range(0, 2));
         ra   = $urandom;
         rw   = $urandom;
         rr   = $urandom;
         run_op($sformatf("rnd%0d", k), kind != 1, kind != 0, 1'($urandom_range(0, 1)),
                ra, rw, int'($urandom_range(1, 6)), rr);
      end

      // Ack on the last permitted WAIT_ACK cycle still completes normally
      run_op("ack_at_limit", 1'b1, 1'b0, 1'b0, 32'h0000_0202, 32'h0, int'(T), 32'hA5A5_5A5A);

      // No ack: timeout aborts the load
      run_op("timeout", 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0, 0, 32'hFFFF_FFFF);

      // Reset while waiting for ack, then a late ack
      ack_dly = 0;
      clear_log();
      @(negedge clk);
      bus.core_rd      = 1'b1;
      bus.core_is_word = 1'b1;
      bus.core_addr    = 32'h0000_0400;
      repeat (3) @(negedge clk);
      #1;
      check("pre_rst mem_req", 64'(bus.mem_req), 64'(1));
      rst_b       = 1'b1;
      bus.core_rd = 1'b0;
      #1;
      exp_err   = 1'b0;
      exp_rdata = '0;
      check("midrst mem_req",    64'(bus.mem_req),    64'(0));
      check("midrst core_err",   64'(bus.core_err),   64'(0));
      check("midrst core_rdata", 64'(bus.core_rdata), 64'(0));
      check("midrst core_stall", 64'(bus.core_stall), 64'(0));
      @(negedge clk);
      rst_b     = 1'b0;
      force_ack = 1'b1;
      @(negedge clk);
      force_ack = 1'b0;
      #1;
      check("late_ack mem_req",    64'(bus.mem_req),    64'(0));
      check("late_ack core_stall", 64'(bus.core_stall), 64'(0));
      check("late_ack core_rdata", 64'(bus.core_rdata), 64'(0));
      repeat (2) @(negedge clk);

      // Minimum latency load after reset
      run_op("ld_min", 1'b1, 1'b0, 1'b1, 32'h0000_0500, 32'h0, 1, 32'h0BAD_BEEF);

`ifdef DATA_MEM_WRITE_BUFFER_EN
      // Posted store followed immediately by a load of the same word
      ack_dly = 3;
      resp    = 32'h5566_7788;
      clear_log();
      @(negedge clk);
      bus.core_wr      = 1'b1;
      bus.core_rd      = 1'b0;
      bus.core_is_word = 1'b1;
      bus.core_addr    = 32'h0000_0020;
      bus.core_wdata   = 32'h1122_3344;
      #1;
      check("wb store_stall", 64'(bus.core_stall), 64'(0));
      @(negedge clk);
      bus.core_wr = 1'b0;
      bus.core_rd = 1'b1;
      #1;
      stalls = 0;
      while (bus.core_stall === 1'b1 && stalls < 60) begin
         stalls++;
         @(negedge clk);
         #1;
      end
      check("wb load_stall", 64'(stalls), 64'(10));
      check("wb txn_count", 64'(rises), 64'(2));
      if (cap_we.size() == 2) begin
         check("wb first_we",  64'(cap_we[0]), 64'(1));
         check("wb second_we", 64'(cap_we[1]), 64'(0));
      end
      check("wb core_rdata", 64'(bus.core_rdata), 64'(32'h5566_7788));
      @(negedge clk);
      bus.core_rd = 1'b0;
      repeat (2) @(negedge clk);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
